// File: rtl/rv32_regfile_alu_unit.sv
// Execution building block for the RV32I multicycle core: 32x32 register file
// with x0 hardwired to zero, a 32-bit ALU with status flags, and an enabled result register.
module rv32_regfile_alu_unit #(
    parameter logic [31:0] RESULT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        wr_ena,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr0,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1,
    input  logic        src_b_sel,
    input  logic [31:0] imm,
    input  logic [3:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        overflow,
    output logic        zero,
    output logic        equal,
    input  logic        result_ena,
    output logic [31:0] result_q
);

    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    // Flat view of all 32 entries; entry 0 is a constant so x0 never holds state.
    logic [31:0][31:0] rf_flat;
    assign rf_flat[0] = 32'h0000_0000;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_entry
            logic [31:0] entry_reg;
            logic        wr_hit;

            assign wr_hit = ena && wr_ena && (wr_addr == 5'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= 32'h0000_0000;
                end else if (wr_hit) begin
                    entry_reg <= wr_data;
                end
            end

            assign rf_flat[gi] = entry_reg;
        end
    endgenerate

    // Reads come straight from stored contents: a same-cycle write is not bypassed.
    assign rd_data0 = rf_flat[rd_addr0];
    assign rd_data1 = rf_flat[rd_addr1];

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] sum;
    logic [31:0] diff;

    assign op_a  = rd_data0;
    assign op_b  = src_b_sel ? imm : rd_data1;
    assign shamt = op_b[4:0];
    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;

    always_comb begin
        alu_result = 32'h0000_0000;
        overflow   = 1'b0;
        case (alu_control)
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_SLL:  alu_result = op_a << shamt;
            OP_SRL:  alu_result = op_a >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
            OP_ADD: begin
                alu_result = sum;
                overflow   = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
            end
            OP_SUB: begin
                alu_result = diff;
                overflow   = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
            end
            OP_SLT:  alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_result = {31'b0, op_a < op_b};
            default: alu_result = 32'h0000_0000;
        endcase
    end

    assign zero  = (alu_result == 32'h0000_0000);
    assign equal = (op_a == op_b);

    logic [31:0] result_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= RESULT_RESET;
        end else if (ena && result_ena) begin
            result_reg <= alu_result;
        end
    end

    assign result_q = result_reg;

endmodule

// File: tb/tb_rv32_regfile_alu_unit.sv
// Directed-vector bench for rv32_regfile_alu_unit with hand-computed expectations.
module tb_rv32_regfile_alu_unit;

    localparam logic [31:0] RST_VAL = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;
    logic        src_b_sel;
    logic [31:0] imm;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        overflow;
    logic        zero;
    logic        equal;
    logic        result_ena;
    logic [31:0] result_q;

    int tests_run = 0;
    int tests_failed = 0;

    rv32_regfile_alu_unit #(
        .RESULT_RESET(RST_VAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .wr_ena     (wr_ena),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rd_data0   (rd_data0),
        .rd_data1   (rd_data1),
        .src_b_sel  (src_b_sel),
        .imm        (imm),
        .alu_control(alu_control),
        .alu_result (alu_result),
        .overflow   (overflow),
        .zero       (zero),
        .equal      (equal),
        .result_ena (result_ena),
        .result_q   (result_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    task automatic reg_write(input logic [4:0] addr, input logic [31:0] data);
        wr_addr = addr;
        wr_data = data;
        wr_ena  = 1'b1;
        @(posedge clk);
        #1;
        wr_ena  = 1'b0;
    endtask

    task automatic alu_check(input string tag, input logic [3:0] op, input logic [31:0] exp_res,
                             input logic exp_ovf, input logic exp_zero, input logic exp_eq);
        alu_control = op;
        #1;
        check({tag, "_res"}, alu_result, exp_res);
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        check({tag, "_eq"}, 32'(equal), 32'(exp_eq));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0; src_b_sel = 1'b0; imm = '0;
        alu_control = 4'b0000; result_ena = 1'b0;
        #12;
        rst = 1'b0;

        // Cleared state on every address through both ports
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd0_x%0d", i), rd_data0, 32'h0);
            check($sformatf("reset_rd1_x%0d", 31 - i), rd_data1, 32'h0);
        end
        check("reset_result_q", result_q, RST_VAL);

        @(posedge clk);
        #1;
        reg_write(5'd5, 32'h7FFF_FFFF);
        reg_write(5'd6, 32'h0000_0001);
        rd_addr0 = 5'd5; rd_addr1 = 5'd6; src_b_sel = 1'b0;
        alu_check("add_ovf", 4'b1000, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        result_ena = 1'b1;
        @(posedge clk);
        #1;
        result_ena = 1'b0;
        check("result_q_load", result_q, 32'h8000_0000);
        alu_control = 4'b0001;
        @(posedge clk);
        #1;
        check("result_q_hold", result_q, 32'h8000_0000);

        // x0 stays zero
        reg_write(5'd0, 32'hDEAD_BEEF);
        rd_addr0 = 5'd0;
        #1;
        check("x0_write_ignored", rd_data0, 32'h0);

        // Same-address read/write: old value before the edge, new after
        reg_write(5'd7, 32'h1111_1111);
        rd_addr0 = 5'd7; rd_addr1 = 5'd7;
        wr_addr = 5'd7; wr_data = 32'h2222_2222; wr_ena = 1'b1;
        #1;
        check("rw_same_before", rd_data0, 32'h1111_1111);
        @(posedge clk);
        #1;
        wr_ena = 1'b0;
        check("rw_same_after0", rd_data0, 32'h2222_2222);
        check("rw_same_after1", rd_data1, 32'h2222_2222);

        // Shifts use only imm[4:0] (36 -> 4)
        reg_write(5'd1, 32'hFFFF_FFF0);
        rd_addr0 = 5'd1; src_b_sel = 1'b1; imm = 32'd36;
        alu_check("sra", 4'b0111, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        alu_check("srl", 4'b0110, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0);
        alu_check("sll", 4'b0101, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0);

        imm = 32'h0F0F_0F0F;
        alu_check("and", 4'b0001, 32'h0F0F_0F00, 1'b0, 1'b0, 1'b0);
        alu_check("or",  4'b0010, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        alu_check("xor", 4'b0011, 32'hF0F0_F0FF, 1'b0, 1'b0, 1'b0);
        imm = 32'hFFFF_FFF0;
        alu_check("invalid0", 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1);
        alu_check("invalid4", 4'b0100, 32'h0, 1'b0, 1'b1, 1'b1);
        alu_check("invalid9", 4'b1001, 32'h0, 1'b0, 1'b1, 1'b1);

        reg_write(5'd2, 32'hFFFF_FFFF);
        reg_write(5'd3, 32'h0000_0001);
        reg_write(5'd4, 32'h8000_0000);
        rd_addr0 = 5'd2; rd_addr1 = 5'd3; src_b_sel = 1'b0;
        alu_check("slt",  4'b1101, 32'h1, 1'b0, 1'b0, 1'b0);
        alu_check("sltu", 4'b1111, 32'h0, 1'b0, 1'b1, 1'b0);
        alu_check("sub_neg", 4'b1100, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        alu_check("add_wrap", 4'b1000, 32'h0, 1'b0, 1'b1, 1'b0);
        rd_addr0 = 5'd4;
        alu_check("sub_ovf", 4'b1100, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);

        reg_write(5'd8, 32'd7);
        rd_addr0 = 5'd8; src_b_sel = 1'b1; imm = 32'd7;
        alu_check("sub_eq", 4'b1100, 32'h0, 1'b0, 1'b1, 1'b1);

        // ena=0: no state change over three clocks, comb paths still live
        ena = 1'b0; wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678; result_ena = 1'b1;
        rd_addr0 = 5'd5; src_b_sel = 1'b1; imm = 32'h0000_00FF; alu_control = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        check("ena0_reg_hold", rd_data0, 32'h7FFF_FFFF);
        check("ena0_result_hold", result_q, 32'h8000_0000);
        check("ena0_alu_live", alu_result, 32'h0000_00FF);
        wr_ena = 1'b0; result_ena = 1'b0; ena = 1'b1;

        // Asynchronous reset between edges, overriding a pending write
        wr_addr = 5'd10; wr_data = 32'hCAFE_F00D; wr_ena = 1'b1; result_ena = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_x5", rd_data0, 32'h0);
        check("async_rst_result_q", result_q, RST_VAL);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_addr0 = 5'd10; rd_addr1 = 5'd7;
        #1;
        check("rst_overrides_write", rd_data0, 32'h0);
        check("rst_cleared_x7", rd_data1, 32'h0);
        wr_ena = 1'b0; result_ena = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rv32_regfile_alu_unit.md
Name: rv32_regfile_alu_unit

Overview:
- Execution building block for the RV32I multicycle core.
- Combines a 32x32 architectural register file (x0 hardwired to zero), a behavioural 32-bit ALU with status flags, and a 32-bit enabled result register.
- The core drives register addresses, ALU control and an immediate. The unit returns combinational read data, the ALU result and flags, and a registered copy of the ALU result.

Parameters:
- RESULT_RESET, 32'h0000_0000, value loaded into the result register on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- ena  in  1  global enable; when 0, no state changes on clk
- wr_ena  in  1  register-file write enable
- wr_addr  in  5  register-file write address
- wr_data  in  32  register-file write data
- rd_addr0  in  5  read port 0 address (rs1)
- rd_addr1  in  5  read port 1 address (rs2)
- rd_data0  out  32  read port 0 data; also ALU operand a
- rd_data1  out  32  read port 1 data
- src_b_sel  in  1  ALU operand b select: 0 = rd_data1, 1 = imm
- imm  in  32  sign-extended immediate
- alu_control  in  4  ALU operation code
- alu_result  out  32  combinational ALU result
- overflow  out  1  signed overflow flag
- zero  out  1  alu_result == 0
- equal  out  1  a == b
- result_ena  in  1  result register load enable
- result_q  out  32  registered ALU result

Behaviour:
- Reset (asynchronous, rst=1, independent of clk and ena):
  - all 32 register-file entries clear to 0.
  - result_q = RESULT_RESET.
  - Combinational outputs follow the cleared state immediately.
  - Reset asserted mid-operation overrides any write pending on the same edge.
- Register file writes:
  - Occur on rising clk when rst=0, ena=1, wr_ena=1 and wr_addr != 0.
  - Writes to x0 are discarded.
- Register file reads:
  - Combinational (zero latency) from stored contents; x0 always reads 0.
  - Read and write to the same address in one cycle: read shows the old value until the edge, the new value after it. No write-through bypass.
  - Both read ports may address the same register.
- ALU operands: a = rd_data0; b = src_b_sel ? imm : rd_data1.
- alu_control encoding (alu_result):
  - 0000 INVALID: 0
  - 0001 AND: a&b
  - 0010 OR: a|b
  - 0011 XOR: a^b
  - 0101 SLL: a << b[4:0]
  - 0110 SRL: logical a >> b[4:0]
  - 0111 SRA: arithmetic a >>> b[4:0]
  - 1000 ADD: a+b, modulo 2^32
  - 1100 SUB: a-b, modulo 2^32
  - 1101 SLT: {31'b0, signed a<b}
  - 1111 SLTU: {31'b0, unsigned a<b}
  - any other code: treated as INVALID (result 0).
- Shifts use only b[4:0]; upper bits of b are ignored.
- overflow:
  - ADD: 1 when a and b have equal sign and the result sign differs.
  - SUB: 1 when a and b have different sign and the result sign differs from a.
  - 0 for all other ops.
- zero = (alu_result == 0), including under INVALID.
- equal = (a == b), regardless of alu_control.
- Result register: on rising clk with rst=0, ena=1, result_ena=1, result_q <= alu_result. Otherwise it holds.
- Latency:
  - rd_data*, alu_result and flags are 0-cycle combinational.
  - result_q lags alu_result by 1 cycle.
  - A written register is visible on rd_data* 1 cycle after the write edge.
- ena=0: wr_ena and result_ena are ignored. Combinational paths stay live.
- Implementation constraints: no latches; all comb outputs fully assigned for every input combination.

Test Plan:
- Reset then read all 32 addresses -> every rd_data0/rd_data1 = 0; result_q = RESULT_RESET.
- Write x5=32'h7FFF_FFFF, x6=1; select ADD, src_b_sel=0, rd_addr0=5, rd_addr1=6 -> alu_result=32'h8000_0000, overflow=1, zero=0, equal=0. With result_ena=1, result_q=32'h8000_0000 the next cycle.
- Write x0=32'hDEAD_BEEF -> rd_data0 at addr 0 stays 0. Read/write same address in one cycle -> old value before the edge, new value after.
- x1=32'hFFFF_FFF0, imm=32'd36, src_b_sel=1:
  - SRA -> 32'hFFFF_FFFF (shift by 4)
  - SRL -> 32'h0FFF_FFFF
  - SLL -> 32'hFFFF_FF00
- SLT with a=-1, b=1 -> 1; SLTU same operands -> 0. SUB with a=b=7 -> result 0, zero=1, equal=1, overflow=0.
- Assert rst mid-cycle between edges after several writes -> outputs clear immediately. With ena=0 and wr_ena=result_ena=1, no state changes across 3 clocks.
